// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame totals from sync trailing edges, locks onto a
// stable geometry and emits active-area coordinates, data enable and aligned pixel colour.
module vga_timing_rx #(
  parameter int HSZ      = 10,
  parameter int VSZ      = 9,
  parameter int H_ACTIVE = 640,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           hsync_i,
  input  logic           vsync_i,
  input  logic [3:0]     r_i,
  input  logic [3:0]     g_i,
  input  logic [3:0]     b_i,
  output logic [HSZ-1:0] hcount_o,
  output logic [VSZ-1:0] vcount_o,
  output logic           de_o,
  output logic [3:0]     r_o,
  output logic [3:0]     g_o,
  output logic [3:0]     b_o,
  output logic           frame_start_o,
  output logic           locked_o,
  output logic [11:0]    htotal_o,
  output logic [11:0]    vtotal_o
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] H_START = 12'(H_BP);
  localparam logic [11:0] H_END   = 12'(H_BP + H_ACTIVE);
  localparam logic [11:0] V_START = 12'(V_BP);
  localparam logic [11:0] V_END   = 12'(V_BP + V_ACTIVE);

  logic           hs1_q, vs1_q, hs2_q, vs2_q;
  logic [11:0]    rgb1_q, rgb2_q;
  logic [11:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [11:0]    htotal_q, htotal_d, vtotal_q, vtotal_d;
  logic [11:0]    ref_h_q, ref_h_d, ref_v_q, ref_v_d;
  logic [1:0]     match_q, match_d;
  state_t         state_q, state_d;
  logic           de_q, de_d, fs_q, fs_d;
  logic [HSZ-1:0] hcount_q, hcount_d;
  logic [VSZ-1:0] vcount_q, vcount_d;
  logic [11:0]    rgb_q, rgb_d;

  logic           hs_in, vs_in, h_fall, v_fall, hcnt_sat, active, timeout;
  logic [11:0]    htotal_meas, vtotal_meas;

  assign hs_in    = SYNC_POL ? hsync_i : ~hsync_i;
  assign vs_in    = SYNC_POL ? vsync_i : ~vsync_i;
  assign h_fall   = hs2_q & ~hs1_q;
  assign v_fall   = vs2_q & ~vs1_q;
  assign hcnt_sat = (hcnt_q == CNT_MAX);
  assign timeout  = hcnt_sat && (state_q != SEARCH);

  // hcnt_q is the position of the pixel held in rgb2_q; measurements use the count just before the edge.
  always_comb begin
    htotal_meas = hcnt_sat ? CNT_MAX : hcnt_q + 12'd1;
    vtotal_meas = vcnt_q + 12'd1;
    hcnt_d      = hcnt_sat ? hcnt_q : hcnt_q + 12'd1;
    vcnt_d      = vcnt_q;
    htotal_d    = htotal_q;
    vtotal_d    = vtotal_q;
    if (h_fall) begin
      hcnt_d   = '0;
      htotal_d = htotal_meas;
      vcnt_d   = vcnt_q + 12'd1;
    end
    if (v_fall) begin
      vcnt_d   = '0;
      vtotal_d = vtotal_meas;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_h_d = ref_h_q;
    ref_v_d = ref_v_q;
    match_d = match_q;
    case (state_q)
      SEARCH: begin
        if (v_fall) begin
          state_d = TRACK;
          ref_h_d = htotal_d;
          ref_v_d = vtotal_meas;
          match_d = '0;
        end
      end
      TRACK: begin
        if (v_fall) begin
          if (vtotal_meas == ref_v_q && htotal_d == ref_h_q) begin
            match_d = match_q + 2'd1;
            if (match_d == 2'd2) state_d = LOCKED;
          end else begin
            ref_h_d = htotal_d;
            ref_v_d = vtotal_meas;
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if ((h_fall && htotal_meas != ref_h_q) || (v_fall && vtotal_meas != ref_v_q))
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
    if (timeout) state_d = SEARCH;
  end

  // Gating with the next state makes de_o fall in the same cycle as locked_o.
  always_comb begin
    active   = (hcnt_q >= H_START) && (hcnt_q < H_END) && (vcnt_q >= V_START) && (vcnt_q < V_END);
    de_d     = active && (state_d == LOCKED);
    hcount_d = '0;
    vcount_d = '0;
    rgb_d    = '0;
    if (de_d) begin
      hcount_d = HSZ'(hcnt_q - H_START);
      vcount_d = VSZ'(vcnt_q - V_START);
      rgb_d    = rgb2_q;
    end
    fs_d = de_d && (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      hs2_q    <= 1'b0;
      vs2_q    <= 1'b0;
      rgb1_q   <= '0;
      rgb2_q   <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      htotal_q <= '0;
      vtotal_q <= '0;
      ref_h_q  <= '0;
      ref_v_q  <= '0;
      match_q  <= '0;
      state_q  <= SEARCH;
      de_q     <= 1'b0;
      fs_q     <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      rgb_q    <= '0;
    end else begin
      hs1_q    <= hs_in;
      vs1_q    <= vs_in;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
      rgb1_q   <= {r_i, g_i, b_i};
      rgb2_q   <= rgb1_q;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      htotal_q <= htotal_d;
      vtotal_q <= vtotal_d;
      ref_h_q  <= ref_h_d;
      ref_v_q  <= ref_v_d;
      match_q  <= match_d;
      state_q  <= state_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      rgb_q    <= rgb_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign de_o          = de_q;
  assign r_o           = rgb_q[11:8];
  assign g_o           = rgb_q[7:4];
  assign b_o           = rgb_q[3:0];
  assign frame_start_o = fs_q;
  assign locked_o      = (state_q == LOCKED);
  assign htotal_o      = htotal_q;
  assign vtotal_o      = vtotal_q;

endmodule
